// File: rtl/program_loader_pkg.sv
// Shared types and defaults for the instruction-store loader: state encoding,
// default memory geometry and the HALT opcode used to pad the unused tail.
package program_loader_pkg;

   localparam int PROG_ADDRESS_SIZE  = 8;
   localparam int INSTRUCTION_SIZE   = 32;
   localparam int PROG_MEMORY_SIZE   = 256;
   localparam logic [31:0] HALT_INST = 32'hFC00_0000;

   typedef enum logic [2:0] {
      LOADER_IDLE  = 3'd0,
      LOADER_LOAD  = 3'd1,
      LOADER_DRAIN = 3'd2,
      LOADER_FILL  = 3'd3,
      LOADER_RUN   = 3'd4
   } loader_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Valid/ready word stream from the external program source into the loader.
interface program_loader_if #(
   parameter int DATA_SIZE = 32
);
   logic                 in_valid;
   logic [DATA_SIZE-1:0] in_data;
   logic                 in_last;
   logic                 in_ready;

   modport master (output in_valid, output in_data, output in_last, input in_ready);
   modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/program_loader.sv
// Program memory loader: streams words into the instruction store, optionally
// pads the tail with HALT, then hands the address port to the core PC.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// LOADER_IDLE  | memory parked at address 0, core stalled, waiting for start
// LOADER_LOAD  | accepting source words, one registered write per beat
// LOADER_DRAIN | final registered write goes out, load_count captured
// LOADER_FILL  | HALT written at counter each cycle up to SIZE-1
// LOADER_RUN   | address follows cpu_pc, core released
module program_loader
   import program_loader_pkg::*;
#(
   parameter int ADDRESS_SIZE                = PROG_ADDRESS_SIZE,
   parameter int DATA_SIZE                   = INSTRUCTION_SIZE,
   parameter int SIZE                        = PROG_MEMORY_SIZE,
   parameter bit FILL_HALT                   = 1'b1,
   parameter logic [DATA_SIZE-1:0] HALT_WORD = DATA_SIZE'(HALT_INST)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    load_start,
   program_loader_if.slave         src,
   input  logic [ADDRESS_SIZE-1:0] cpu_pc,
   output logic                    mem_write_enable,
   output logic [ADDRESS_SIZE-1:0] mem_address,
   output logic [DATA_SIZE-1:0]    mem_data_in,
   output logic                    cpu_stall,
   output logic                    load_done,
   output logic                    overflow,
   output logic [ADDRESS_SIZE:0]   load_count
);

   localparam int CW = ADDRESS_SIZE + 1;
   localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
   localparam logic [CW-1:0] LAST_C = CW'(SIZE - 1);

   loader_state_e           state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    wr_en_q, wr_en_d;
   logic [ADDRESS_SIZE-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_SIZE-1:0]    wr_data_q, wr_data_d;
   logic                    ovf_q, ovf_d;
   logic [CW-1:0]           lcnt_q, lcnt_d;

   // Ready is a pure function of state so the source can never form a loop through it.
   assign src.in_ready = (state_q == LOADER_LOAD);
   assign overflow     = ovf_q;
   assign load_count   = lcnt_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= LOADER_IDLE;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         ovf_q     <= 1'b0;
         lcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         ovf_q     <= ovf_d;
         lcnt_q    <= lcnt_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      wr_en_d          = 1'b0;
      wr_addr_d        = wr_addr_q;
      wr_data_d        = wr_data_q;
      ovf_d            = ovf_q;
      lcnt_d           = lcnt_q;
      mem_write_enable = 1'b0;
      mem_address      = '0;
      mem_data_in      = '0;
      cpu_stall        = 1'b1;
      load_done        = 1'b0;

      unique case (state_q)
         LOADER_IDLE: begin
            if (load_start) begin
               state_d = LOADER_LOAD;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         LOADER_LOAD: begin
            mem_write_enable = wr_en_q;
            mem_address      = wr_addr_q;
            mem_data_in      = wr_data_q;
            if (src.in_valid) begin
               wr_en_d   = 1'b1;
               wr_addr_d = cnt_q[ADDRESS_SIZE-1:0];
               wr_data_d = src.in_data;
               cnt_d     = cnt_q + CW'(1);
               if (src.in_last || (cnt_q == LAST_C)) state_d = LOADER_DRAIN;
               if ((cnt_q == LAST_C) && !src.in_last) ovf_d = 1'b1;
            end
         end
         LOADER_DRAIN: begin
            mem_write_enable = wr_en_q;
            mem_address      = wr_addr_q;
            mem_data_in      = wr_data_q;
            lcnt_d           = (cnt_q > SIZE_C) ? SIZE_C : cnt_q;
            state_d          = (FILL_HALT && (cnt_q < SIZE_C)) ? LOADER_FILL : LOADER_RUN;
         end
         LOADER_FILL: begin
            mem_write_enable = 1'b1;
            mem_address      = cnt_q[ADDRESS_SIZE-1:0];
            mem_data_in      = HALT_WORD;
            cnt_d            = cnt_q + CW'(1);
            if (cnt_q >= LAST_C) state_d = LOADER_RUN;
         end
         LOADER_RUN: begin
            mem_address = cpu_pc;
            cpu_stall   = 1'b0;
            load_done   = 1'b1;
            if (load_start) begin
               state_d = LOADER_LOAD;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = LOADER_IDLE;
      endcase
   end

endmodule

// File: doc/program_loader.md
# program_loader

Sequencing controller for the instruction store. It owns the program memory's write port and address mux. After a start pulse it streams instruction words from an external source (debug/UART bridge) into consecutive addresses over a valid/ready handshake, optionally pads the unused tail with `HALT_INST`, then hands the address port to the core's PC and releases the stall.

## Interface
Parameters:
- ADDRESS_SIZE, `ADDRESS_SIZE, program memory address width
- DATA_SIZE, `INSTRUCTION_SIZE, instruction word width
- SIZE, `PROG_MEMORY_SIZE, number of words (SIZE ≤ 2^ADDRESS_SIZE)
- FILL_HALT, 1, when 1, pad addresses past the last loaded word with `HALT_INST

Ports:
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- load_start  in  1  one-cycle request to (re)load the program
- in_valid  in  1  source word valid
- in_data  in  DATA_SIZE  source instruction word
- in_last  in  1  qualifies in_data as final word
- in_ready  out  1  loader accepts a word this cycle
- cpu_pc  in  ADDRESS_SIZE  core fetch address
- mem_write_enable  out  1  program memory write strobe
- mem_address  out  ADDRESS_SIZE  program memory address
- mem_data_in  out  DATA_SIZE  program memory write data
- cpu_stall  out  1  holds the core while the memory is not released
- load_done  out  1  high in RUN
- overflow  out  1  sticky; image exceeded SIZE
- load_count  out  ADDRESS_SIZE+1  words accepted in the last load

## Operation
- States: IDLE, LOAD, DRAIN, FILL, RUN.
- Reset (reset=0 at edge): state IDLE. All outputs 0 except cpu_stall=1. Counter, pipeline register, overflow and load_count are cleared.
- IDLE:
  - cpu_stall=1, in_ready=0, mem_address=0.
  - load_start → LOAD; counter and overflow cleared.
- LOAD:
  - in_ready=1.
  - An accepted beat (in_valid & in_ready) captures in_data and address=counter into the write register; the counter increments.
  - An accepted beat with in_last=1, or a beat at counter=SIZE-1, ends the load → DRAIN. If the address was SIZE-1 and in_last=0, overflow is set.
  - load_start in LOAD is ignored.
- DRAIN: one cycle, in_ready=0, for the final registered write. load_count ← counter. Then:
  - → FILL if FILL_HALT=1 and counter<SIZE;
  - else → RUN.
- FILL:
  - One write per cycle of `HALT_INST at address counter; the counter increments.
  - The write at SIZE-1 → RUN.
- RUN:
  - mem_address=cpu_pc (combinational), mem_write_enable=0, cpu_stall=0, load_done=1.
  - load_start → LOAD; cpu_stall=1 from the next cycle.
- Width rules:
  - The counter is ADDRESS_SIZE+1 bits and never exceeds SIZE.
  - mem_address takes the low ADDRESS_SIZE bits.
  - load_count saturates at SIZE.
- Zero-word load is impossible: LOAD waits indefinitely for the first beat.

## Timing
- Write latency is 1 cycle: a beat accepted at edge N drives mem_write_enable/mem_address/mem_data_in during cycle N+1, and the memory commits at edge N+1.
- in_ready is combinational from state only; it never depends on in_valid.
- Back-to-back accepted beats yield one write per cycle.
- Last beat accepted at edge N: the DRAIN write is in cycle N+1.
  - With FILL_HALT=1, FILL writes run from cycle N+2.
  - Without fill, RUN starts at cycle N+2 (load_done=1, cpu_stall=0).
- FILL duration is SIZE − load_count cycles.
- Reset mid-LOAD or mid-FILL: IDLE on the next edge and the write strobe drops immediately. Partially written contents are not restored.
- load_start with reset=0 in the same cycle: reset wins.

## Structure
- The state encodings (LOADER_IDLE … LOADER_RUN) go in the shared header architecture.vh, next to `HALT_INST and the size macros.
- No sub-module is needed: a single module holds the FSM, counter, write register and address mux.
- The top level wires mem_* to the program memory write port.

## Test plan
Bench: SIZE=16, ADDRESS_SIZE=4, DATA_SIZE=32.
- Reset: hold reset=0 for 2 cycles → cpu_stall=1, load_done=0, in_ready=0, mem_write_enable=0, load_count=0.
- Load 3 words (0xA0, 0xA1, 0xA2; last on the third), FILL_HALT=0:
  - writes at addresses 0, 1, 2, each one cycle after acceptance;
  - load_count=3;
  - RUN two cycles after the last beat;
  - mem_address follows cpu_pc=5.
- Same 3 words with FILL_HALT=1 → addresses 3..15 receive `HALT_INST over 13 consecutive cycles, then RUN.
- Stall the source by toggling in_valid → no write in cycles without an accepted beat; addresses stay contiguous 0..N-1.
- Send 17 words with no in_last:
  - the beat at address 15 ends the load; in_ready=0 afterwards;
  - overflow=1, load_count=16.
- Reset asserted on the 2nd beat of a 4-word load → IDLE next edge, no further writes. A new load_start then reloads from address 0.
